// File: rtl/chase_pkg.sv
// Shared definitions for the chase game engine: FSM states, directions, IR key codes,
// colours, game-length presets and small geometry helpers.
package chase_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_OVER  = 2'd2,
        ST_PAUSE = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        DIR_UP,
        DIR_DOWN,
        DIR_LEFT,
        DIR_RIGHT
    } dir_e;

    localparam logic [7:0] KEY_STOP  = 8'h00;
    localparam logic [7:0] KEY_UP    = 8'h02;
    localparam logic [7:0] KEY_LEFT  = 8'h04;
    localparam logic [7:0] KEY_PAUSE = 8'h05;
    localparam logic [7:0] KEY_RIGHT = 8'h06;
    localparam logic [7:0] KEY_DOWN  = 8'h08;

    localparam logic [23:0] RGB_PLAYER  = 24'h0000FF;
    localparam logic [23:0] RGB_FOOD    = 24'h00FF00;
    localparam logic [23:0] RGB_BG      = 24'h000000;
    localparam logic [23:0] RGB_BG_OVER = 24'h400000;

    function automatic int time_preset(input logic [1:0] sel);
        case (sel)
            2'b00:   return 10;
            2'b01:   return 30;
            2'b10:   return 60;
            default: return 90;
        endcase
    endfunction

    // True when a and b are no further apart than r.
    function automatic logic near(input logic [9:0] a, input logic [9:0] b, input int r);
        logic [9:0] d;
        d = (a > b) ? a - b : b - a;
        return int'(d) <= r;
    endfunction

    function automatic logic [9:0] lfsr_seed(input int k);
        return 10'(k * 97 + 13);
    endfunction

    function automatic logic [9:0] food_home_x(input int i);
        case (i)
            0:       return 10'd380;
            1:       return 10'd100;
            2:       return 10'd540;
            default: return 10'd100;
        endcase
    endfunction

    function automatic logic [9:0] food_home_y(input int i);
        case (i)
            0:       return 10'd240;
            1:       return 10'd100;
            2:       return 10'd400;
            default: return 10'd400;
        endcase
    endfunction

endpackage

// File: rtl/chase_if.sv
// Bus between the chase engine and its neighbours: IR key strobe in, pixel colour query.
interface chase_if;
    logic        ir_valid;
    logic [7:0]  ir_key;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic [23:0] pix_rgb;

    modport master (output ir_valid, ir_key, pix_x, pix_y, input pix_rgb);
    modport slave  (input ir_valid, ir_key, pix_x, pix_y, output pix_rgb);
endinterface

// File: rtl/chase_lfsr.sv
// 10-bit free-running Fibonacci LFSR, taps 10 and 7; SEED must be non-zero.
module chase_lfsr #(
    parameter logic [9:0] SEED = 10'h001
) (
    input  logic       clk,
    input  logic       rst,
    output logic [9:0] q
);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) q <= SEED;
        else      q <= {q[8:0], q[9] ^ q[6]};
    end
endmodule

// File: rtl/chase_game_core.sv
// Chase game engine: IR direction FSM, player motion, LFSR food respawn, scoring, timer and
// registered per-pixel colour. Define CHASE_WALL_WRAP_EN to wrap at screen edges instead of clamping.
module chase_game_core
    import chase_pkg::*;
#(
    parameter int H_ACT     = 640,
    parameter int V_ACT     = 480,
    parameter int OBJ_HALF  = 25,
    parameter int FOOD_HALF = 5,
    parameter int N_FOOD    = 2,
    parameter int MOVE_DIV  = 500000,
    parameter int SEC_DIV   = 50000000,
    parameter int STEP      = 1,
    parameter int SCORE_W   = 7,
    parameter int TIME_W    = 7
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_n,
    input  logic [1:0]         time_sel,
    chase_if.slave             bus,
    output logic [1:0]         game_state,
    output logic               paused,
    output logic [SCORE_W-1:0] score,
    output logic [TIME_W-1:0]  time_left,
    output logic [9:0]         obj_x,
    output logic [9:0]         obj_y
);
    localparam int MOVE_W = $clog2(MOVE_DIV + 1);
    localparam int SEC_W  = $clog2(SEC_DIV + 1);
    localparam int HIT_R  = OBJ_HALF + FOOD_HALF;

    state_e            state_q, state_d;
    dir_e              dir_q;
    logic              start_meta, start_s;
    logic [MOVE_W-1:0] move_cnt;
    logic [SEC_W-1:0]  sec_cnt;
    logic              move_tick, sec_tick, do_move;
    logic [9:0]        nxt_x, nxt_y;
    logic [9:0]        food_x [N_FOOD];
    logic [9:0]        food_y [N_FOOD];
    logic [9:0]        lfsr_x [N_FOOD];
    logic [9:0]        lfsr_y [N_FOOD];
    logic [N_FOOD-1:0] food_vld, eat_oh, spawn_ok;
    logic              eat_any, food_px;
    logic [23:0]       rgb_d;

    always_ff @(posedge clk or negedge rst) begin
        // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
        if (!rst) begin
            start_meta <= 1'b1;
            start_s    <= 1'b1;
        end else begin
            start_meta <= start_n;
            start_s    <= start_meta;
        end
    end

    // Move counter always free-runs; the second counter only advances while playing.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            move_cnt <= '0;
            sec_cnt  <= '0;
        end else begin
            move_cnt <= move_tick ? '0 : move_cnt + 1'b1;
            if (state_q == ST_RUN)        sec_cnt <= sec_tick ? '0 : sec_cnt + 1'b1;
            else if (state_q != ST_PAUSE) sec_cnt <= '0;
        end
    end

    assign move_tick = (move_cnt == MOVE_W'(MOVE_DIV - 1));
    assign sec_tick  = (sec_cnt == SEC_W'(SEC_DIV - 1));
    assign do_move   = move_tick && (state_q == ST_RUN);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        // NOTE: defaults first so no path through this block leaves state_d unassigned (no latch).
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (!start_s) state_d = ST_RUN;
            ST_RUN: begin
                if (bus.ir_valid && bus.ir_key == KEY_STOP)       state_d = ST_IDLE;
                else if (time_left == '0)                         state_d = ST_OVER;
                else if (bus.ir_valid && bus.ir_key == KEY_PAUSE) state_d = ST_PAUSE;
            end
            ST_PAUSE: begin
                if (bus.ir_valid && bus.ir_key == KEY_STOP)       state_d = ST_IDLE;
                else if (bus.ir_valid && bus.ir_key == KEY_PAUSE) state_d = ST_RUN;
            end
            ST_OVER:  if (!start_s) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        int nx;
        int ny;
        nx = int'(obj_x);
        ny = int'(obj_y);
        case (dir_q)
            DIR_UP:    ny = ny - STEP;
            DIR_DOWN:  ny = ny + STEP;
            DIR_LEFT:  nx = nx - STEP;
            default:   nx = nx + STEP;
        endcase
`ifdef CHASE_WALL_WRAP_EN
        if (nx < 0) nx = H_ACT - 1; else if (nx > H_ACT - 1) nx = 0;
        if (ny < 0) ny = V_ACT - 1; else if (ny > V_ACT - 1) ny = 0;
`else
        if (nx < OBJ_HALF) nx = OBJ_HALF; else if (nx > H_ACT - 1 - OBJ_HALF) nx = H_ACT - 1 - OBJ_HALF;
        if (ny < OBJ_HALF) ny = OBJ_HALF; else if (ny > V_ACT - 1 - OBJ_HALF) ny = V_ACT - 1 - OBJ_HALF;
`endif
        nxt_x = 10'(nx);
        nxt_y = 10'(ny);
    end

    // Collision uses the post-move position; the lowest-index target wins.
    always_comb begin
        eat_oh  = '0;
        eat_any = 1'b0;
        for (int i = 0; i < N_FOOD; i++) begin
            if (!eat_any && food_vld[i] && near(nxt_x, food_x[i], HIT_R) && near(nxt_y, food_y[i], HIT_R)) begin
                eat_oh[i] = 1'b1;
                eat_any   = 1'b1;
            end
        end
    end

    for (genvar g = 0; g < N_FOOD; g++) begin : g_food
        chase_lfsr #(.SEED(lfsr_seed(2 * g)))     u_lfsr_x (.clk(clk), .rst(rst), .q(lfsr_x[g]));
        chase_lfsr #(.SEED(lfsr_seed(2 * g + 1))) u_lfsr_y (.clk(clk), .rst(rst), .q(lfsr_y[g]));
        assign spawn_ok[g] = (lfsr_x[g] >= 10'(FOOD_HALF)) && (lfsr_x[g] < 10'(H_ACT - FOOD_HALF)) &&
                             (lfsr_y[g] >= 10'(FOOD_HALF)) && (lfsr_y[g] < 10'(V_ACT - FOOD_HALF));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dir_q     <= DIR_UP;
            obj_x     <= 10'(H_ACT / 2);
            obj_y     <= 10'(V_ACT / 2);
            score     <= '0;
            time_left <= '0;
        end else begin
            if (state_q == ST_RUN) begin
                if (bus.ir_valid) begin
                    case (bus.ir_key)
                        KEY_UP:    dir_q <= DIR_UP;
                        KEY_DOWN:  dir_q <= DIR_DOWN;
                        KEY_LEFT:  dir_q <= DIR_LEFT;
                        KEY_RIGHT: dir_q <= DIR_RIGHT;
                        default:   ;
                    endcase
                end
                if (do_move) begin
                    obj_x <= nxt_x;
                    obj_y <= nxt_y;
                    if (eat_any && score != '1) score <= score + 1'b1;
                end
                if (sec_tick && time_left != '0) time_left <= time_left - 1'b1;
            end
            if (state_q == ST_IDLE && state_d == ST_RUN) begin
                time_left <= TIME_W'(time_preset(time_sel));
                dir_q     <= DIR_UP;
                score     <= '0;
            end
            if ((state_q == ST_RUN || state_q == ST_PAUSE) && state_d == ST_IDLE) score <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: this small target table is reset explicitly so each food starts valid at home.
            for (int i = 0; i < N_FOOD; i++) begin
                food_x[i] <= food_home_x(i);
                food_y[i] <= food_home_y(i);
            end
            food_vld <= '1;
        end else begin
            for (int i = 0; i < N_FOOD; i++) begin
                if (food_vld[i]) begin
                    if (do_move && eat_oh[i]) food_vld[i] <= 1'b0;
                end else if (spawn_ok[i]) begin
                    food_x[i]   <= lfsr_x[i];
                    food_y[i]   <= lfsr_y[i];
                    food_vld[i] <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        food_px = 1'b0;
        for (int i = 0; i < N_FOOD; i++) begin
            if (food_vld[i] && near(bus.pix_x, food_x[i], FOOD_HALF) && near(bus.pix_y, food_y[i], FOOD_HALF))
                food_px = 1'b1;
        end
        if (near(bus.pix_x, obj_x, OBJ_HALF) && near(bus.pix_y, obj_y, OBJ_HALF)) rgb_d = RGB_PLAYER;
        else if (food_px)                                                         rgb_d = RGB_FOOD;
        else if (state_q == ST_OVER)                                              rgb_d = RGB_BG_OVER;
        else                                                                      rgb_d = RGB_BG;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) bus.pix_rgb <= '0;
        else      bus.pix_rgb <= rgb_d;
    end

    assign game_state = (state_q == ST_OVER) ? 2'd2 : (state_q == ST_IDLE) ? 2'd0 : 2'd1;
    assign paused     = (state_q == ST_PAUSE);

endmodule

// File: tb/tb_chase_game_core.sv
// Directed bench for chase_game_core with fast tick dividers; honours CHASE_WALL_WRAP_EN.
module tb_chase_game_core;
    import chase_pkg::*;

    localparam int MOVE_DIV = 4;
    localparam int SEC_DIV  = 40;

    typedef struct packed {
        logic [9:0]  x;
        logic [9:0]  y;
        logic [23:0] rgb;
    } pix_vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start_n = 1'b1;
    logic [1:0] time_sel = 2'b00;
    logic [1:0] game_state;
    logic       paused;
    logic [6:0] score, time_left;
    logic [9:0] obj_x, obj_y;
    int         errors = 0;
    int         checks = 0;
    pix_vec_t   pix_tab [12];

    chase_if bus();

    chase_game_core #(.MOVE_DIV(MOVE_DIV), .SEC_DIV(SEC_DIV)) dut (
        .clk(clk), .rst(rst), .start_n(start_n), .time_sel(time_sel), .bus(bus),
        .game_state(game_state), .paused(paused), .score(score), .time_left(time_left),
        .obj_x(obj_x), .obj_y(obj_y)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic send_key(input logic [7:0] k);
        bus.ir_key   = k;
        bus.ir_valid = 1'b1;
        @(negedge clk);
        bus.ir_valid = 1'b0;
    endtask

    task automatic start_game(input logic [1:0] sel, input int exp_time, input string name);
        time_sel = sel;
        start_n  = 1'b0;
        repeat (3) @(negedge clk);
        start_n  = 1'b1;
        check({name, "_state"}, 32'(game_state), 1);
        check({name, "_time"}, 32'(time_left), exp_time);
    endtask

    task automatic wait_move(input string name);
        logic [9:0] x0, y0;
        bit hit;
        x0 = obj_x; y0 = obj_y; hit = 1'b0;
        for (int i = 0; i < 3 * MOVE_DIV; i++) begin
            @(negedge clk);
            if (obj_x !== x0 || obj_y !== y0) begin hit = 1'b1; break; end
        end
        if (!hit) timeout(name);
    endtask

    task automatic wait_x(input logic [9:0] target, input int budget, input string name);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (obj_x == target) begin hit = 1'b1; break; end
            @(negedge clk);
        end
        if (!hit) timeout(name);
    endtask

    task automatic query_pix(input logic [9:0] x, input logic [9:0] y, input logic [23:0] exp, input string name);
        bus.pix_x = x;
        bus.pix_y = y;
        @(negedge clk);
        check(name, 32'(bus.pix_rgb), 32'(exp));
    endtask

    initial begin
        logic [9:0] x0, y0;
        logic [6:0] t0;
        bit hit;

        bus.ir_valid = 1'b0;
        bus.ir_key   = 8'h00;
        bus.pix_x    = 10'd0;
        bus.pix_y    = 10'd0;

        pix_tab[0]  = '{10'd320, 10'd240, RGB_PLAYER};
        pix_tab[1]  = '{10'd345, 10'd265, RGB_PLAYER};
        pix_tab[2]  = '{10'd295, 10'd215, RGB_PLAYER};
        pix_tab[3]  = '{10'd346, 10'd240, RGB_BG};
        pix_tab[4]  = '{10'd380, 10'd240, RGB_FOOD};
        pix_tab[5]  = '{10'd375, 10'd245, RGB_FOOD};
        pix_tab[6]  = '{10'd374, 10'd240, RGB_BG};
        pix_tab[7]  = '{10'd386, 10'd240, RGB_BG};
        pix_tab[8]  = '{10'd100, 10'd100, RGB_FOOD};
        pix_tab[9]  = '{10'd95,  10'd105, RGB_FOOD};
        pix_tab[10] = '{10'd0,   10'd0,   RGB_BG};
        pix_tab[11] = '{10'd639, 10'd479, RGB_BG};

        // Reset state and idle-screen colour table
        do_reset();
        check("rst_state", 32'(game_state), 0);
        check("rst_paused", 32'(paused), 0);
        check("rst_score", 32'(score), 0);
        check("rst_time", 32'(time_left), 0);
        check("rst_obj_x", 32'(obj_x), 320);
        check("rst_obj_y", 32'(obj_y), 240);
        check("rst_pix", 32'(bus.pix_rgb), 0);
        for (int i = 0; i < 12; i++)
            query_pix(pix_tab[i].x, pix_tab[i].y, pix_tab[i].rgb, $sformatf("pix_vec%0d", i));

        // Start with 30 s, player climbs one pixel per move tick
        start_game(2'b01, 30, "t1");
        check("t1_obj_x", 32'(obj_x), 320);
        check("t1_obj_y", 32'(obj_y), 240);
        wait_move("t1_move1");
        check("t1_up1_x", 32'(obj_x), 320);
        check("t1_up1_y", 32'(obj_y), 239);
        wait_move("t1_move2");
        check("t1_up2_y", 32'(obj_y), 238);

        // Turn right, pause/resume, unknown key, stop
        send_key(KEY_RIGHT);
        check("t2_x_at_turn", 32'(obj_x), 320);
        y0 = obj_y;
        wait_move("t2_move1");
        check("t2_right1_x", 32'(obj_x), 321);
        check("t2_right1_y", 32'(obj_y), 32'(y0));
        wait_move("t2_move2");
        check("t2_right2_x", 32'(obj_x), 322);
        send_key(KEY_PAUSE);
        check("t2_paused", 32'(paused), 1);
        check("t2_pause_state", 32'(game_state), 1);
        x0 = obj_x; y0 = obj_y; t0 = time_left;
        repeat (100) @(negedge clk);
        check("t2_frozen_x", 32'(obj_x), 32'(x0));
        check("t2_frozen_y", 32'(obj_y), 32'(y0));
        check("t2_frozen_time", 32'(time_left), 32'(t0));
        send_key(KEY_PAUSE);
        check("t2_resumed", 32'(paused), 0);
        wait_move("t2_move3");
        check("t2_resume_x", 32'(obj_x), 32'(x0 + 10'd1));
        send_key(8'h33);
        check("t2_unknown_state", 32'(game_state), 1);
        check("t2_unknown_paused", 32'(paused), 0);
        x0 = obj_x;
        wait_move("t2_move4");
        check("t2_unknown_x", 32'(obj_x), 32'(x0 + 10'd1));
        send_key(KEY_STOP);
        check("t2_stop_state", 32'(game_state), 0);
        check("t2_stop_score", 32'(score), 0);

        // Eat food 0 at (380,240) moving right: overlap starts at obj_x=350
        do_reset();
        start_game(2'b01, 30, "t3");
        send_key(KEY_RIGHT);
        wait_x(10'd349, 200, "t3_reach349");
        check("t3_score_before", 32'(score), 0);
        wait_x(10'd350, 2 * MOVE_DIV, "t3_reach350");
        check("t3_score_after", 32'(score), 1);
        check("t3_food_eaten", 32'(dut.food_vld[0]), 0);
        hit = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (dut.food_vld[0]) begin hit = 1'b1; break; end
        end
        if (!hit) timeout("t3_respawn");
        check("t3_resp_x_range", 32'(dut.food_x[0] >= 10'd5 && dut.food_x[0] < 10'd635), 1);
        check("t3_resp_y_range", 32'(dut.food_y[0] >= 10'd5 && dut.food_y[0] < 10'd475), 1);

        // Asynchronous reset mid-game with a non-zero score
        check("t6_score_nonzero", 32'(score != 7'd0), 1);
        #2 rst = 1'b0;
        #1;
        check("t6_state", 32'(game_state), 0);
        check("t6_paused", 32'(paused), 0);
        check("t6_score", 32'(score), 0);
        check("t6_time", 32'(time_left), 0);
        check("t6_obj_x", 32'(obj_x), 320);
        check("t6_obj_y", 32'(obj_y), 240);
        check("t6_pix", 32'(bus.pix_rgb), 0);
        @(negedge clk);
        rst = 1'b1;
        query_pix(10'd0, 10'd0, RGB_BG, "t6_pix_after");

        // 10 s game runs out: OVER the cycle after time_left hits 0
        start_game(2'b00, 10, "t4");
        hit = 1'b0;
        for (int i = 0; i < SEC_DIV + 10; i++) begin
            @(negedge clk);
            if (time_left != 7'd10) begin hit = 1'b1; break; end
        end
        if (!hit) timeout("t4_first_sec");
        check("t4_time9", 32'(time_left), 9);
        hit = 1'b0;
        for (int i = 0; i < 10 * SEC_DIV; i++) begin
            @(negedge clk);
            if (time_left == 7'd0) begin hit = 1'b1; break; end
        end
        if (!hit) timeout("t4_time0");
        check("t4_still_run", 32'(game_state), 1);
        @(negedge clk);
        check("t4_over", 32'(game_state), 2);
        check("t4_time_zero", 32'(time_left), 0);
        query_pix(10'd0, 10'd0, RGB_BG_OVER, "t4_pix_over_bg");
        query_pix(10'd100, 10'd100, RGB_FOOD, "t4_pix_over_food");
        check("t4_time_no_wrap", 32'(time_left), 0);
        start_n = 1'b0;
        @(negedge clk);
        start_n = 1'b1;
        repeat (4) @(negedge clk);
        check("t4_back_idle", 32'(game_state), 0);

        // Drive into the left wall
        do_reset();
        start_game(2'b11, 90, "t5");
        send_key(KEY_LEFT);
        wait_x(10'd25, 1400, "t5_reach25");
        y0 = obj_y;
`ifdef CHASE_WALL_WRAP_EN
        wait_x(10'd0, 200, "t5_reach0");
        wait_move("t5_wrap_move");
        check("t5_wrap_x", 32'(obj_x), 639);
        check("t5_wrap_y", 32'(obj_y), 32'(y0));
`else
        repeat (10 * MOVE_DIV) @(negedge clk);
        check("t5_clamp_x", 32'(obj_x), 25);
        check("t5_clamp_y", 32'(obj_y), 32'(y0));
`endif
        check("t5_running", 32'(game_state), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
